atm_multi_ctrl: RTL and testbench
=================================

ATM_MULTI_CTRL -- requirements
Module: atm_multi_ctrl

Interface
REQ-001 SHALL have parameter BAL_W, 16, balance and amount width in bits.
REQ-002 SHALL have parameter ACCT_N, 4, number of accounts (power of two, 2..16).
REQ-003 SHALL have parameter MAX_TRIES, 3, wrong-PIN attempts before lockout.
REQ-004 SHALL have parameter INIT_BAL, 10000, reset balance of every account.
REQ-005 SHALL have parameter TIMEOUT_CYC, 1000, inactivity limit in cycles (used only with ATM_TIMEOUT_EN).
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports card_inserted, pin_entered, pin_correct, eject_req, lock_clear  in  1 each  session controls.
REQ-009 SHALL have port acct_sel  in  $clog2(ACCT_N)  account index, sampled in IDLE.
REQ-010 SHALL have port menu_option  in  2  00 none, 01 balance, 10 withdraw, 11 deposit.
REQ-011 SHALL have port amount  in  BAL_W  withdraw/deposit amount.
REQ-012 SHALL have ports balance  out  BAL_W  (selected-account balance) and state  out  3  (current state).
REQ-013 SHALL have ports card_eject, card_retained, txn_ok, txn_err  out  1 each.

Function
REQ-014 SHALL encode states IDLE=0, CHECK_PIN=1, MAIN_MENU=2, SHOW_BAL=3, WITHDRAW=4, DEPOSIT=5, EJECT=6, LOCKED=7.
REQ-015 IDLE: on card_inserted SHALL latch acct_sel, clear try count, and go to CHECK_PIN next cycle.
REQ-016 CHECK_PIN: pin_entered&pin_correct SHALL go to MAIN_MENU; pin_entered&!pin_correct SHALL increment tries, staying in CHECK_PIN, or go to LOCKED when tries reach MAX_TRIES.
REQ-017 MAIN_MENU: eject_req SHALL take priority over menu_option and go to EJECT; else 01/10/11 SHALL go to SHOW_BAL/WITHDRAW/DEPOSIT; 00 SHALL hold.
REQ-018 SHOW_BAL SHALL last one cycle, then MAIN_MENU; balance output SHALL always reflect the latched account.
REQ-019 WITHDRAW SHALL, in one cycle, subtract amount if balance >= amount and pulse txn_ok, else leave balance unchanged and pulse txn_err; then MAIN_MENU.
REQ-020 DEPOSIT SHALL add amount if the BAL_W-bit sum does not overflow and pulse txn_ok, else leave balance unchanged and pulse txn_err; then MAIN_MENU.
REQ-021 Updated balance SHALL be visible on balance the cycle after txn_ok.
REQ-022 EJECT SHALL assert card_eject for exactly one cycle, then IDLE.
REQ-023 LOCKED SHALL hold card_retained=1 and ignore all inputs except lock_clear, which SHALL go to IDLE with card_retained=0 next cycle.
REQ-024 txn_ok and txn_err SHALL be single-cycle pulses and never asserted together.
REQ-025 Amount 0 SHALL succeed (txn_ok) with balance unchanged.

Reset
REQ-026 Reset SHALL force state=IDLE, all ACCT_N balances=INIT_BAL, tries=0, card_eject=card_retained=txn_ok=txn_err=0, latched account=0.
REQ-027 Reset SHALL override every other input in the same cycle, including mid-transaction and in LOCKED.

Configuration
REQ-028 With ATM_TIMEOUT_EN defined, a counter SHALL clear on any of pin_entered, eject_req, or non-zero menu_option, and on reaching TIMEOUT_CYC cycles in CHECK_PIN or MAIN_MENU SHALL force EJECT.
REQ-029 Without ATM_TIMEOUT_EN, no counter SHALL exist and CHECK_PIN/MAIN_MENU SHALL wait indefinitely.

Structure
REQ-030 Package atm_pkg SHALL hold the state enumeration and the menu-option codes.
REQ-031 Balances SHALL live in sub-module atm_acct_bank (ACCT_N x BAL_W registers, one write port, one combinational read port, reset to INIT_BAL).

Verification
REQ-032 Insert acct 2, correct PIN, menu 10 amount 3000 -> txn_ok, balance 7000; acct 0 still 10000.
REQ-033 Withdraw 12000 from 10000 -> txn_err, balance 10000, back to MAIN_MENU.
REQ-034 BAL_W=16, balance 65000, deposit 1000 -> txn_err, balance 65000; deposit 535 -> txn_ok, 65535.
REQ-035 Three wrong PINs (MAX_TRIES=3) -> LOCKED, card_retained=1; card_inserted ignored; lock_clear -> IDLE.
REQ-036 MAIN_MENU with eject_req=1 and menu_option=10 together -> EJECT, one-cycle card_eject, balance unchanged.
REQ-037 With ATM_TIMEOUT_EN, TIMEOUT_CYC=20, idle in MAIN_MENU 20 cycles -> EJECT; reset during WITHDRAW -> IDLE, balances 10000.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared state encoding and menu-option codes for the ATM controller.
package atm_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK_PIN = 3'd1,
    MAIN_MENU = 3'd2,
    SHOW_BAL  = 3'd3,
    WITHDRAW  = 3'd4,
    DEPOSIT   = 3'd5,
    EJECT     = 3'd6,
    LOCKED    = 3'd7
  } state_t;
  localparam logic [1:0] MENU_NONE = 2'b00;
  localparam logic [1:0] MENU_BAL  = 2'b01;
  localparam logic [1:0] MENU_WD   = 2'b10;
  localparam logic [1:0] MENU_DEP  = 2'b11;
endpackage

// File: rtl/atm_multi_ctrl_if.sv
// atm_multi_ctrl_if: session controls and status bundle between the ATM front end and controller.
interface atm_multi_ctrl_if #(
  parameter int BAL_W  = 16,
  parameter int ACCT_N = 4
);
  logic                      card_inserted;
  logic                      pin_entered;
  logic                      pin_correct;
  logic                      eject_req;
  logic                      lock_clear;
  logic [$clog2(ACCT_N)-1:0] acct_sel;
  logic [1:0]                menu_option;
  logic [BAL_W-1:0]          amount;
  logic [BAL_W-1:0]          balance;
  logic [2:0]                state;
  logic                      card_eject;
  logic                      card_retained;
  logic                      txn_ok;
  logic                      txn_err;
  modport master (
    output card_inserted, pin_entered, pin_correct, eject_req, lock_clear,
           acct_sel, menu_option, amount,
    input  balance, state, card_eject, card_retained, txn_ok, txn_err
  );
  modport slave (
    input  card_inserted, pin_entered, pin_correct, eject_req, lock_clear,
           acct_sel, menu_option, amount,
    output balance, state, card_eject, card_retained, txn_ok, txn_err
  );
endinterface

// File: rtl/atm_acct_bank.sv
// atm_acct_bank: ACCT_N balance registers, one write port, one combinational read port.
module atm_acct_bank #(
  parameter int BAL_W    = 16,
  parameter int ACCT_N   = 4,
  parameter int INIT_BAL = 10000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [$clog2(ACCT_N)-1:0] waddr,
  input  logic [BAL_W-1:0]          wdata,
  input  logic [$clog2(ACCT_N)-1:0] raddr,
  output logic [BAL_W-1:0]          rdata
);
  logic [BAL_W-1:0] bal [ACCT_N];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ACCT_N; i++) bal[i] <= BAL_W'(INIT_BAL);
    end else if (we) begin
      bal[waddr] <= wdata;
    end
  end
  assign rdata = bal[raddr];
endmodule

// File: rtl/atm_multi_ctrl.sv
// atm_multi_ctrl: multi-account ATM session controller (PIN check, lockout, balance/withdraw/deposit).
// Define ATM_TIMEOUT_EN to eject the card after TIMEOUT_CYC idle cycles in CHECK_PIN/MAIN_MENU.
module atm_multi_ctrl
  import atm_pkg::*;
#(
  parameter int BAL_W       = 16,
  parameter int ACCT_N      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int INIT_BAL    = 10000,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  atm_multi_ctrl_if.slave  bus
);
  localparam int AW = $clog2(ACCT_N);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t           state_q, state_d;
  logic [AW-1:0]    acct_q;
  logic [TW-1:0]    tries_q, tries_d;
  logic [BAL_W-1:0] bal, wdata;
  logic [BAL_W:0]   sum;
  logic             wd_ok, dep_ok, we, tmo;
  atm_acct_bank #(.BAL_W(BAL_W), .ACCT_N(ACCT_N), .INIT_BAL(INIT_BAL)) bank (
    .clk(clk), .reset(reset), .we(we), .waddr(acct_q), .wdata(wdata),
    .raddr(acct_q), .rdata(bal)
  );
  // The extra sum bit is the deposit overflow flag.
  assign sum    = {1'b0, bal} + {1'b0, bus.amount};
  assign wd_ok  = bal >= bus.amount;
  assign dep_ok = !sum[BAL_W];
  assign we     = state_q == WITHDRAW ? wd_ok : state_q == DEPOSIT && dep_ok;
  assign wdata  = state_q == WITHDRAW ? bal - bus.amount : sum[BAL_W-1:0];
  assign bus.txn_ok        = we;
  assign bus.txn_err       = (state_q == WITHDRAW && !wd_ok) || (state_q == DEPOSIT && !dep_ok);
  assign bus.balance       = bal;
  assign bus.state         = state_q;
  assign bus.card_eject    = state_q == EJECT;
  assign bus.card_retained = state_q == LOCKED;
`ifdef ATM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q;
  logic          act, wait_st;
  assign act     = bus.pin_entered || bus.eject_req || bus.menu_option != MENU_NONE;
  assign wait_st = state_q == CHECK_PIN || state_q == MAIN_MENU;
  always_ff @(posedge clk) begin
    if (reset || act || !wait_st) tmo_q <= '0;
    else tmo_q <= tmo_q + 1'b1;
  end
  assign tmo = wait_st && !act && tmo_q == CW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acct_q  <= '0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      if (state_q == IDLE && bus.card_inserted) acct_q <= bus.acct_sel;
    end
  end
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    case (state_q)
      IDLE: if (bus.card_inserted) begin
        state_d = CHECK_PIN;
        tries_d = '0;
      end
      CHECK_PIN: if (tmo) state_d = EJECT;
      else if (bus.pin_entered && bus.pin_correct) state_d = MAIN_MENU;
      else if (bus.pin_entered) begin
        tries_d = tries_q + 1'b1;
        state_d = tries_q == TW'(MAX_TRIES - 1) ? LOCKED : CHECK_PIN;
      end
      MAIN_MENU: state_d = tmo || bus.eject_req          ? EJECT :
                           bus.menu_option == MENU_BAL   ? SHOW_BAL :
                           bus.menu_option == MENU_WD    ? WITHDRAW :
                           bus.menu_option == MENU_DEP   ? DEPOSIT : MAIN_MENU;
      SHOW_BAL, WITHDRAW, DEPOSIT: state_d = MAIN_MENU;
      EJECT:   state_d = IDLE;
      LOCKED:  if (bus.lock_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_atm_multi_ctrl.sv
// tb_atm_multi_ctrl: scoreboard bench for atm_multi_ctrl; timeout scenario runs when ATM_TIMEOUT_EN is defined.
module tb_atm_multi_ctrl;
  typedef struct {
    logic        ok;
    logic [15:0] bal;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ref_bal [4];
  int   cur = 0;
  exp_t sb [$];
  exp_t e;
  logic pend = 1'b0;
  logic [15:0] pbal;
  atm_multi_ctrl_if #(.BAL_W(16), .ACCT_N(4)) bus ();
  atm_multi_ctrl #(
    .BAL_W(16), .ACCT_N(4), .MAX_TRIES(3), .INIT_BAL(10000), .TIMEOUT_CYC(20)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  // Result monitor: pops an expectation for each txn pulse and checks the balance one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      chk("bal_after_txn", bus.balance, pbal);
      pend = 1'b0;
    end
    if (bus.txn_ok || bus.txn_err) begin
      chk("ok_err_excl", bus.txn_ok & bus.txn_err, 0);
      if (sb.size() == 0) chk("sb_unexpected_txn", 1, 0);
      else begin
        e = sb.pop_front();
        chk("txn_ok", bus.txn_ok, e.ok);
        chk("txn_err", bus.txn_err, !e.ok);
        pbal = e.bal;
        pend = 1'b1;
      end
    end
  end
  task automatic session(input int acct, input int wrong);
    cur = acct;
    bus.acct_sel = 2'(acct);
    bus.card_inserted = 1'b1;
    tick();
    bus.card_inserted = 1'b0;
    chk("st_check_pin", bus.state, 1);
    for (int i = 0; i < wrong; i++) begin
      bus.pin_entered = 1'b1;
      tick();
      bus.pin_entered = 1'b0;
      chk("st_retry", bus.state, 1);
    end
    bus.pin_entered = 1'b1;
    bus.pin_correct = 1'b1;
    tick();
    bus.pin_entered = 1'b0;
    bus.pin_correct = 1'b0;
    chk("st_menu", bus.state, 2);
    chk("bal_sel", bus.balance, ref_bal[acct]);
  endtask
  task automatic txn(input logic [1:0] opt, input int amt);
    int   b;
    logic ok;
    b  = ref_bal[cur];
    ok = opt == 2'b10 ? amt <= b : b + amt <= 65535;
    if (ok) ref_bal[cur] = opt == 2'b10 ? b - amt : b + amt;
    sb.push_back('{ok, 16'(ref_bal[cur])});
    bus.menu_option = opt;
    bus.amount = 16'(amt);
    tick();
    bus.menu_option = 2'b00;
    chk("st_txn", bus.state, opt == 2'b10 ? 4 : 5);
    tick();
    chk("st_back_menu", bus.state, 2);
  endtask
  task automatic eject();
    bus.eject_req = 1'b1;
    bus.menu_option = 2'b10;
    tick();
    bus.eject_req = 1'b0;
    bus.menu_option = 2'b00;
    chk("st_eject", bus.state, 6);
    chk("card_eject_on", bus.card_eject, 1);
    chk("bal_eject", bus.balance, ref_bal[cur]);
    tick();
    chk("st_idle", bus.state, 0);
    chk("card_eject_off", bus.card_eject, 0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) ref_bal[i] = 10000;
    {bus.card_inserted, bus.pin_entered, bus.pin_correct, bus.eject_req, bus.lock_clear} = '0;
    bus.acct_sel = '0;
    bus.menu_option = '0;
    bus.amount = '0;
    repeat (2) tick();
    chk("rst_state", bus.state, 0);
    chk("rst_bal", bus.balance, 10000);
    chk("rst_eject", bus.card_eject, 0);
    chk("rst_retained", bus.card_retained, 0);
    chk("rst_ok", bus.txn_ok, 0);
    chk("rst_err", bus.txn_err, 0);
    reset = 1'b0;
    tick();
    session(2, 0);
    txn(2'b10, 3000);
    eject();
    session(0, 2);
    txn(2'b10, 12000);
    txn(2'b11, 55000);
    txn(2'b11, 1000);
    txn(2'b11, 535);
    txn(2'b10, 0);
    txn(2'b11, 0);
    bus.menu_option = 2'b01;
    tick();
    bus.menu_option = 2'b00;
    chk("st_show_bal", bus.state, 3);
    tick();
    chk("st_show_back", bus.state, 2);
    chk("bal_65535", bus.balance, 65535);
    eject();
    session(2, 0);
    chk("acct2_kept", bus.balance, 7000);
    eject();
    // Lockout: a fresh card starts with zero tries even after earlier wrong PINs.
    bus.acct_sel = 2'd1;
    bus.card_inserted = 1'b1;
    tick();
    bus.card_inserted = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pin_entered = 1'b1;
      tick();
      bus.pin_entered = 1'b0;
      chk("st_wrong_pin", bus.state, i == 2 ? 7 : 1);
    end
    chk("retained_on", bus.card_retained, 1);
    bus.card_inserted = 1'b1;
    bus.pin_entered = 1'b1;
    bus.pin_correct = 1'b1;
    repeat (3) begin
      tick();
      chk("st_locked_hold", bus.state, 7);
    end
    {bus.card_inserted, bus.pin_entered, bus.pin_correct} = '0;
    bus.lock_clear = 1'b1;
    tick();
    bus.lock_clear = 1'b0;
    chk("st_unlock", bus.state, 0);
    chk("retained_off", bus.card_retained, 0);
`ifdef ATM_TIMEOUT_EN
    session(3, 0);
    repeat (19) tick();
    chk("st_tmo_wait", bus.state, 2);
    tick();
    chk("st_tmo_eject", bus.state, 6);
    tick();
    chk("st_tmo_idle", bus.state, 0);
`else
    session(3, 0);
    repeat (40) tick();
    chk("st_no_tmo", bus.state, 2);
    eject();
`endif
    // Reset lands in the same cycle as the WITHDRAW pulse, so no write may occur.
    session(0, 0);
    sb.push_back('{1'b1, 16'd10000});
    bus.menu_option = 2'b10;
    bus.amount = 16'd100;
    tick();
    bus.menu_option = 2'b00;
    chk("st_mid_wd", bus.state, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) ref_bal[i] = 10000;
    cur = 0;
    chk("st_rst_mid", bus.state, 0);
    chk("bal_rst_mid", bus.balance, 10000);
    tick();
    session(2, 0);
    chk("acct2_rst", bus.balance, 10000);
    eject();
    chk("sb_drained", sb.size(), 0);
    chk("no_pending", pend, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
